axil_master: RTL

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_pkg.sv | 31 +++
 rtl/axil_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axil_pkg
// Brief   : Shared types and constants for the AXI4-Lite single-beat master.
// Revision: 1.0 - initial release
// ============================================================================
package axil_pkg;

    // AXI response codes as they appear on bResp / rResp.
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Transaction sequencer states; only one transaction is ever in flight.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } axil_state_e;

    // Default protection attributes: unprivileged, secure, data access.
    localparam logic [2:0] C_PROT_DEFAULT = 3'b000;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_master.sv
`default_nettype none
// ============================================================================
// Module  : axil_master
// Brief   : Converts a simple command/response interface into single AXI4-Lite
//           read or write transactions, one outstanding at a time.
// Revision: 1.0 - initial release
// ============================================================================
module axil_master
    import axil_pkg::*;
#(
    parameter logic [2:0] PROT = C_PROT_DEFAULT
) (
    input  logic        aclk,
    input  logic        areset,
    // command side
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdWrite,
    input  logic [31:0] cmdAddr,
    input  logic [31:0] cmdData,
    input  logic [3:0]  cmdStrb,
    // response side
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspData,
    output logic [1:0]  rspResp,
    // write address channel
    output logic [31:0] awAddr,
    output logic [2:0]  awProt,
    output logic        awValid,
    input  logic        awReady,
    // write data channel
    output logic [31:0] wData,
    output logic [3:0]  wStrb,
    output logic        wValid,
    input  logic        wReady,
    // write response channel
    input  logic [1:0]  bResp,
    input  logic        bValid,
    output logic        bReady,
    // read address channel
    output logic [31:0] arAddr,
    output logic [2:0]  arProt,
    output logic        arValid,
    input  logic        arReady,
    // read data channel
    input  logic [31:0] rData,
    input  logic [1:0]  rResp,
    input  logic        rValid,
    output logic        rReady
);

    axil_state_e r_state;
    axil_state_e w_state_nxt;

    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_strb;
    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_resp;

    logic        w_cmd_fire;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_b_fire;
    logic        w_r_fire;

    assign w_cmd_fire = cmdValid && cmdReady;
    assign w_aw_fire  = awValid && awReady;
    assign w_w_fire   = wValid && wReady;
    assign w_b_fire   = bValid && bReady;
    assign w_r_fire   = rValid && rReady;

    // Payloads come straight from the command registers; both address
    // channels share the single captured address.
    assign awAddr  = r_addr;
    assign arAddr  = r_addr;
    assign wData   = r_data;
    assign wStrb   = r_strb;
    assign awProt  = PROT;
    assign arProt  = PROT;
    assign rspData = r_rsp_data;
    assign rspResp = r_rsp_resp;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs. Valids/readies derive only from the
    // state register and done flags, so they are glitch-free and drop to zero
    // the instant reset forces IDLE.
    always_comb begin
        w_state_nxt = r_state;
        cmdReady    = 1'b0;
        awValid     = 1'b0;
        wValid      = 1'b0;
        bReady      = 1'b0;
        arValid     = 1'b0;
        rReady      = 1'b0;
        rspValid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by reset so no command is taken while it is held.
                cmdReady = !areset;
                if (cmdValid && !areset) begin
                    w_state_nxt = cmdWrite ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                // Each channel retires independently; move on once both have.
                awValid = !r_aw_done;
                wValid  = !r_w_done;
                if ((r_aw_done || awReady) && (r_w_done || wReady)) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bReady = 1'b1;
                if (bValid) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                arValid = 1'b1;
                if (arReady) begin
                    w_state_nxt = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                rReady = 1'b1;
                if (rValid) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                rspValid = 1'b1;
                if (rspReady) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-channel completion flags for the write request phase; cleared
    // whenever the sequencer is anywhere else so each write starts fresh.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == ST_WR_REQ) begin
            if (w_aw_fire) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_fire) begin
                r_w_done <= 1'b1;
            end
        end else begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end
    end

    // Command payload capture and response capture; held until the next
    // event that overwrites them so AXI and response payloads stay stable.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_strb     <= '0;
            r_rsp_data <= '0;
            r_rsp_resp <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_addr <= cmdAddr;
                r_data <= cmdData;
                r_strb <= cmdStrb;
            end
            if (w_b_fire) begin
                r_rsp_data <= '0;
                r_rsp_resp <= bResp;
            end else if (w_r_fire) begin
                r_rsp_data <= rData;
                r_rsp_resp <= rResp;
            end
        end
    end

endmodule : axil_master
`default_nettype wire
